dice_roll_generator: RTL

- Upstream feeder for the pair/triple detector.
- Turns a raw, bouncy "roll" push-button into a clean roll request.
- On each request, draws NUM_DICE uniformly distributed die values (1..6) from a free-running LFSR; dice flagged in hold_mask keep their previous value.
- Presents the packed dice word with a one-cycle valid strobe for the detector to consume.

---
 rtl/dice_pkg.sv | 19 +
 rtl/button_debouncer.sv | 45 ++++
 rtl/dice_roll_generator.sv | 100 ++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared constants, FSM state type and LFSR/die helpers for the dice roll generator.
package dice_pkg;
  localparam int          DIE_W     = 3;
  localparam logic [2:0]  DIE_MIN   = 3'd1;
  localparam logic [2:0]  DIE_MAX   = 3'd6;
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, ROLL, DONE} state_e;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic die_ok(input logic [DIE_W-1:0] v);
    return (v >= DIE_MIN) && (v <= DIE_MAX);
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter; emits the clean level and a
// one-cycle pulse when that level rises.
module button_debouncer #(
  parameter int MAX_COUNT = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CNT_W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          rise_q  <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/dice_roll_generator.sv
// Debounced roll button drives an LFSR-based die roller; held dice keep their
// value, completed rolls are flagged with a single-cycle dice_valid.
module dice_roll_generator
  import dice_pkg::*;
#(
  parameter int          MAX_COUNT = 10000,
  parameter int          NUM_DICE  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      roll_btn,
  input  logic [NUM_DICE-1:0]       hold_mask,
  output logic [DIE_W*NUM_DICE-1:0] dice_out,
  output logic                      dice_valid,
  output logic                      busy
);
  localparam int IDX_W = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DICE - 1);

  logic btn_level, btn_rise, roll_req;

  button_debouncer #(.MAX_COUNT(MAX_COUNT)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (roll_btn),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

  assign roll_req = btn_rise & btn_level;

  logic [LFSR_W-1:0]         lfsr_q;
  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DIE_W*NUM_DICE-1:0] dice_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      hold_cur;
  logic                      resolve;

  // Free-running: the draw depends on when the roll lands, not just on roll count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  assign hold_cur = hold_mask[idx_q];
  assign resolve  = hold_cur | die_ok(lfsr_q[DIE_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dice_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (roll_req && ena) begin
            state_q <= ROLL;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ROLL: begin
          // Codes 0 and 7 are rejected; the same die retries on the next LFSR value.
          if (resolve) begin
            for (int i = 0; i < NUM_DICE; i++)
              if (idx_q == IDX_W'(i) && !hold_cur)
                dice_q[i*DIE_W +: DIE_W] <= lfsr_q[DIE_W-1:0];
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dice_out   = dice_q;
  assign dice_valid = valid_q;
  assign busy       = busy_q;
endmodule
